// File: rtl/fifo_level_flush.sv
// Synchronous FIFO with occupancy level flags, sticky overflow and a
// synchronous flush. OUT_REG selects a direct memory-read head or a
// one-entry registered output stage that adds one entry of capacity.
`timescale 1ns/1ps
module fifo_level_flush #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1,
    parameter int OUT_REG   = 0,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int OCP_W    = $clog2(DEPTH + OUT_REG + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    output logic             o_input_ready,
    input  logic             i_input_valid,
    input  logic [WIDTH-1:0] i_input_data,
    input  logic             i_output_ready,
    output logic             o_output_valid,
    output logic [WIDTH-1:0] o_output_data,
    output logic [OCP_W-1:0] o_occupy,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic             o_overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCP_W-1:0] occupy_q;
    logic             overflow_q;
    logic             push;
    logic             pop;
    logic             mem_rd;   // memory head consumed this cycle
    logic             mem_full;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready never looks at a same-cycle pop, so a full FIFO stays closed.
    assign o_input_ready  = !mem_full && !i_flush;
    assign push           = i_input_valid && o_input_ready;
    assign pop            = i_output_ready && o_output_valid;
    assign o_occupy       = occupy_q;
    assign o_overflow     = overflow_q;
    assign o_almost_full  = int'(occupy_q) >= AFULL_TH;
    assign o_almost_empty = int'(occupy_q) <= AEMPTY_TH;

    generate
        if (OUT_REG == 0) begin : g_direct
            assign mem_full       = (occupy_q == OCP_W'(DEPTH));
            assign mem_rd         = pop;
            assign o_output_valid = (occupy_q != '0);
            assign o_output_data  = mem[rd_ptr];
        end else begin : g_outreg
            logic [OCP_W-1:0] mem_cnt;
            logic             out_vld;
            logic [WIDTH-1:0] out_data;

            assign mem_full       = (mem_cnt == OCP_W'(DEPTH));
            // Refill the head register whenever it is free or leaving.
            assign mem_rd         = (!out_vld || pop) && (mem_cnt != '0);
            assign o_output_valid = out_vld;
            assign o_output_data  = out_data;

            // Track memory-only fill level and head register validity.
            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    mem_cnt <= '0;
                    out_vld <= 1'b0;
                end else if (i_flush) begin
                    mem_cnt <= '0;
                    out_vld <= 1'b0;
                end else begin
                    case ({push, mem_rd})
                        2'b10:   mem_cnt <= mem_cnt + OCP_W'(1);
                        2'b01:   mem_cnt <= mem_cnt - OCP_W'(1);
                        default: mem_cnt <= mem_cnt;
                    endcase
                    if (mem_rd)   out_vld <= 1'b1;
                    else if (pop) out_vld <= 1'b0;
                end
            end

            // Head data register; contents are don't-care while invalid.
            always_ff @(posedge i_clk) begin
                if (mem_rd && !i_flush) out_data <= mem[rd_ptr];
            end
        end
    endgenerate

    // Storage write; memory is never cleared.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_input_data;
    end

    // Pointers, total occupancy and sticky overflow; flush wins over traffic.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupy_q   <= '0;
            overflow_q <= 1'b0;
        end else if (i_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupy_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push)   wr_ptr <= ptr_inc(wr_ptr);
            if (mem_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   occupy_q <= occupy_q + OCP_W'(1);
                2'b01:   occupy_q <= occupy_q - OCP_W'(1);
                default: occupy_q <= occupy_q;
            endcase
            if (i_input_valid && !o_input_ready) overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_level_flush.sv
// Bench for fifo_level_flush: two instances (DEPTH=3 direct head,
// DEPTH=4 registered head) driven by directed and random traffic, with a
// count-based reference model and a data scoreboard.
`timescale 1ns/1ps
module tb_fifo_level_flush;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] iv, orr, fl;
    logic [7:0] id0, id1;
    logic [1:0] rdy, vld, af, ae, ovf;
    logic [7:0] od0, od1;
    logic [1:0] oc0;
    logic [2:0] oc1;

    int checks = 0;
    int errors = 0;

    // Reference model: entries held in memory, head-register slot, overflow.
    int mc[2];
    bit mov[2];
    bit movf[2];
    logic [7:0] eq0[$];
    logic [7:0] eq1[$];

    always #5 clk = ~clk;

    fifo_level_flush #(.WIDTH(8), .DEPTH(3), .OUT_REG(0)) u0 (
        .i_clk(clk), .i_reset(rst), .i_flush(fl[0]), .o_input_ready(rdy[0]),
        .i_input_valid(iv[0]), .i_input_data(id0), .i_output_ready(orr[0]),
        .o_output_valid(vld[0]), .o_output_data(od0), .o_occupy(oc0),
        .o_almost_full(af[0]), .o_almost_empty(ae[0]), .o_overflow(ovf[0]));

    fifo_level_flush #(.WIDTH(8), .DEPTH(4), .OUT_REG(1)) u1 (
        .i_clk(clk), .i_reset(rst), .i_flush(fl[1]), .o_input_ready(rdy[1]),
        .i_input_valid(iv[1]), .i_input_data(id1), .i_output_ready(orr[1]),
        .o_output_valid(vld[1]), .o_output_data(od1), .o_occupy(oc1),
        .o_almost_full(af[1]), .o_almost_empty(ae[1]), .o_overflow(ovf[1]));

    function automatic int dp(input int i);   return (i == 0) ? 3 : 4; endfunction
    function automatic bit oreg(input int i); return i != 0;             endfunction
    function automatic int afth(input int i); return (i == 0) ? 2 : 3; endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_inst(input int i, input logic r, input logic v, input int occ,
                              input logic a_f, input logic a_e, input logic o_f);
        int e_occ;
        e_occ = mc[i] + int'(mov[i]);
        chk($sformatf("u%0d_ready", i), r, int'((mc[i] != dp(i)) && !fl[i]));
        chk($sformatf("u%0d_valid", i), v, oreg(i) ? int'(mov[i]) : int'(mc[i] != 0));
        chk($sformatf("u%0d_occupy", i), occ, e_occ);
        chk($sformatf("u%0d_afull", i), a_f, int'(e_occ >= afth(i)));
        chk($sformatf("u%0d_aempty", i), a_e, int'(e_occ <= 1));
        chk($sformatf("u%0d_overflow", i), o_f, int'(movf[i]));
    endtask

    // Advance the model by one clock edge given this cycle's inputs.
    task automatic step(input int i, input logic v, input logic f, input logic r,
                        output bit pushed);
        bit rdy_e, vld_e, pp, load;
        rdy_e  = (mc[i] != dp(i)) && !f;
        vld_e  = oreg(i) ? mov[i] : (mc[i] != 0);
        pushed = 1'b0;
        if (f) begin
            mc[i] = 0; mov[i] = 1'b0; movf[i] = 1'b0;
        end else begin
            pushed = v && rdy_e;
            pp     = r && vld_e;
            if (v && !rdy_e) movf[i] = 1'b1;
            if (oreg(i)) begin
                load   = (!mov[i] || pp) && (mc[i] != 0);
                mc[i]  = mc[i] + int'(pushed) - int'(load);
                mov[i] = load || (mov[i] && !pp);
            end else begin
                mc[i] = mc[i] + int'(pushed) - int'(pp);
            end
        end
    endtask

    // Model: compare flags mid-cycle, then record accepted pushes.
    always @(negedge clk) begin
        bit p0, p1;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin mc[i] = 0; mov[i] = 1'b0; movf[i] = 1'b0; end
            eq0.delete();
            eq1.delete();
        end
        check_inst(0, rdy[0], vld[0], int'(oc0), af[0], ae[0], ovf[0]);
        check_inst(1, rdy[1], vld[1], int'(oc1), af[1], ae[1], ovf[1]);
        if (rst) begin
            step(0, iv[0], fl[0], orr[0], p0);
            step(1, iv[1], fl[1], orr[1], p1);
            if (fl[0]) eq0.delete(); else if (p0) eq0.push_back(id0);
            if (fl[1]) eq1.delete(); else if (p1) eq1.push_back(id1);
        end
    end

    // Monitor: every DUT pop handshake must deliver the oldest expected item.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst && !fl[0] && vld[0] && orr[0]) begin
            if (eq0.size() == 0) chk("u0_pop_unexpected", 1, 0);
            else begin e = eq0.pop_front(); chk("u0_data", od0, e); end
        end
        if (rst && !fl[1] && vld[1] && orr[1]) begin
            if (eq1.size() == 0) chk("u1_pop_unexpected", 1, 0);
            else begin e = eq1.pop_front(); chk("u1_data", od1, e); end
        end
    end

    // One clock of stimulus; entered and left at 1ns after a rising edge.
    task automatic drive(input logic [1:0] v, input logic [1:0] r, input logic [1:0] f,
                         input logic [7:0] d0, input logic [7:0] d1);
        iv = v; orr = r; fl = f; id0 = d0; id1 = d1;
        @(posedge clk); #1;
        iv = '0; orr = '0; fl = '0;
    endtask

    initial begin
        rst = 1'b0; iv = '0; orr = '0; fl = '0; id0 = '0; id1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Post-reset state
        chk("rst_ready", rdy, 2'b11);
        chk("rst_aempty", ae, 2'b11);
        chk("rst_afull", af, 2'b00);
        chk("rst_valid", vld, 2'b00);
        chk("rst_occ1", oc1, 0);

        // Fill DEPTH=3 and drain in order
        for (int k = 0; k < 3; k++) drive(2'b01, 2'b00, 2'b00, 8'hA1 + 8'(k), 8'h00);
        chk("fill_ready", rdy[0], 0);
        chk("fill_occ", oc0, 3);
        chk("fill_afull", af[0], 1);
        for (int k = 0; k < 3; k++) drive(2'b00, 2'b01, 2'b00, 8'h00, 8'h00);
        chk("drain_occ", oc0, 0);
        chk("drain_aempty", ae[0], 1);

        // Streaming push+pop through pointer wrap
        drive(2'b01, 2'b00, 2'b00, 8'h10, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            drive(2'b01, 2'b01, 2'b00, 8'h10 + 8'(k), 8'h00);
            chk("stream_occ", oc0, 1);
        end
        drive(2'b00, 2'b01, 2'b00, 8'h00, 8'h00);

        // Overflow is sticky until flush
        for (int k = 0; k < 3; k++) drive(2'b01, 2'b00, 2'b00, 8'h20 + 8'(k), 8'h00);
        for (int k = 0; k < 2; k++) begin
            drive(2'b01, 2'b00, 2'b00, 8'h55, 8'h00);
            chk("ovf_set", ovf[0], 1);
            chk("ovf_occ", oc0, 3);
        end
        drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        chk("ovf_held", ovf[0], 1);
        drive(2'b00, 2'b00, 2'b01, 8'h00, 8'h00);
        chk("flush_ovf", ovf[0], 0);
        chk("flush_occ", oc0, 0);

        // Flush beats a simultaneous push and pop
        for (int k = 0; k < 2; k++) drive(2'b01, 2'b00, 2'b00, 8'h40 + 8'(k), 8'h00);
        drive(2'b01, 2'b01, 2'b01, 8'h66, 8'h00);
        chk("flush_pp_occ", oc0, 0);
        chk("flush_pp_valid", vld[0], 0);

        // Registered head: 2-cycle latency, capacity 5, 1/cycle drain
        drive(2'b10, 2'b00, 2'b00, 8'h00, 8'hB0);
        chk("oreg_lat1_valid", vld[1], 0);
        drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        chk("oreg_lat2_valid", vld[1], 1);
        for (int k = 1; k <= 4; k++) drive(2'b10, 2'b00, 2'b00, 8'h00, 8'hB0 + 8'(k));
        chk("oreg_full_occ", oc1, 5);
        chk("oreg_full_ready", rdy[1], 0);
        for (int k = 0; k < 5; k++) begin
            drive(2'b00, 2'b10, 2'b00, 8'h00, 8'h00);
            chk("oreg_drain_occ", oc1, 4 - k);
        end

        // Asynchronous reset mid-operation
        for (int k = 0; k < 3; k++) drive(2'b11, 2'b00, 2'b00, 8'h30 + 8'(k), 8'hC0 + 8'(k));
        rst = 1'b0;
        #2;
        chk("arst_occ0", oc0, 0);
        chk("arst_valid", vld, 2'b00);
        @(posedge clk); #1 rst = 1'b1;
        drive(2'b11, 2'b00, 2'b00, 8'h77, 8'h78);
        drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        drive(2'b00, 2'b11, 2'b00, 8'h00, 8'h00);

        // Random traffic alternating push-heavy and pop-heavy phases
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] v, r, f;
            int pv, pr;
            pv = ((n / 400) % 2 == 0) ? 80 : 35;
            pr = ((n / 400) % 2 == 0) ? 35 : 85;
            for (int i = 0; i < 2; i++) begin
                v[i] = ($urandom_range(0, 99) < pv);
                r[i] = ($urandom_range(0, 99) < pr);
                f[i] = ($urandom_range(0, 99) < 2);
            end
            drive(v, r, f, 8'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_level_flush.md
FIFO_LEVEL_FLUSH -- requirements
Module: fifo_level_flush

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning memory entries; any integer >= 2, not restricted to powers of two.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-1, meaning the almost-full threshold on o_occupy.
REQ-004 SHALL have parameter AEMPTY_TH, default 1, meaning the almost-empty threshold on o_occupy.
REQ-005 SHALL have parameter OUT_REG, default 0, meaning 0 for memory-read output and 1 for a registered output stage.
REQ-006 SHALL have derived parameters PTR_W = $clog2(DEPTH) and OCP_W = $clog2(DEPTH+OUT_REG+1).
REQ-007 i_clk  input  1  clock; all state updates on the rising edge.
REQ-008 i_reset  input  1  reset, asynchronous, active-low.
REQ-009 i_flush  input  1  synchronous flush request.
REQ-010 o_input_ready  output  1  push side can accept data.
REQ-011 i_input_valid  input  1  push request.
REQ-012 i_input_data  input  WIDTH  push data.
REQ-013 i_output_ready  output-side consumer  input  1  pop request.
REQ-014 o_output_valid  output  1  head data valid.
REQ-015 o_output_data  output  WIDTH  head data.
REQ-016 o_occupy  output  OCP_W  total entries held, memory plus output register.
REQ-017 o_almost_full  output  1  o_occupy >= AFULL_TH.
REQ-018 o_almost_empty  output  1  o_occupy <= AEMPTY_TH.
REQ-019 o_overflow  output  1  sticky flag marking a rejected push attempt.

Function
REQ-020 Push SHALL occur when i_input_valid & o_input_ready; pop SHALL occur when i_output_ready & o_output_valid.
REQ-021 With OUT_REG=0:
  - o_input_ready SHALL equal (o_occupy != DEPTH) & !i_flush.
  - o_output_valid SHALL equal o_occupy != 0.
  - o_output_data SHALL be mem[rd_ptr].
REQ-022 With OUT_REG=0, data pushed in cycle N SHALL be visible with o_output_valid=1 in cycle N+1; there is no same-cycle bypass.
REQ-023 When full, o_input_ready SHALL be 0 even if a pop occurs in the same cycle.
REQ-024 Write and read pointers SHALL each advance by 1 on push/pop respectively, wrapping from DEPTH-1 to 0 for any DEPTH.
REQ-025 Simultaneous push and pop SHALL leave o_occupy unchanged; push only SHALL add 1; pop only SHALL subtract 1.
REQ-026 With OUT_REG=1, output register behaviour SHALL be:
  - o_output_data/o_output_valid SHALL come from a one-entry register.
  - The register SHALL load from the memory head whenever it is empty or being popped while memory is non-empty.
  - Push-to-valid latency SHALL be 2 cycles.
  - Capacity SHALL be DEPTH+1.
  - o_input_ready SHALL depend only on memory fullness and i_flush.
REQ-027 With OUT_REG=1, back-to-back pops SHALL sustain one item per cycle while data is available.
REQ-028 o_almost_full and o_almost_empty SHALL be combinational functions of the registered o_occupy.
REQ-029 o_overflow SHALL be set on any cycle with i_input_valid=1 & o_input_ready=0 & i_flush=0, and SHALL stay set until flush or reset.
REQ-030 When i_flush=1, the next edge SHALL apply the flush:
  - Pointers, o_occupy, the output-register valid and o_overflow SHALL be cleared.
  - A push or pop in the same cycle SHALL be ignored and SHALL NOT move the pointers.
REQ-031 Memory contents SHALL NOT be reset or cleared; output data SHALL be don't-care while o_output_valid=0.
REQ-032 Order of data SHALL be strictly first-in-first-out across wrap-around and flush.

Reset
REQ-033 On i_reset low, the following SHALL clear asynchronously: wr_ptr=0, rd_ptr=0, o_occupy=0, o_output_valid=0, o_overflow=0.
REQ-034 Directly after reset, o_input_ready=1, o_almost_empty=1, o_almost_full=0 (if AFULL_TH>0).
REQ-035 Reset asserted mid-operation SHALL discard all held entries; the first pop after release SHALL return the first post-reset push.

Verification
REQ-036 DEPTH=3, OUT_REG=0: push A,B,C -> o_input_ready=0, o_occupy=3, o_almost_full=1; pop x3 -> A,B,C; o_occupy=0, o_almost_empty=1.
REQ-037 DEPTH=3: 10 items with continuous push+pop after one preload -> exact order preserved through pointer wrap 2->0; o_occupy stays 1.
REQ-038 Full FIFO, i_input_valid=1 for 2 cycles -> no write, o_overflow=1 and held; i_flush -> o_overflow=0, o_occupy=0 next cycle.
REQ-039 Occupy 2, i_flush=1 with i_input_valid=1 and i_output_ready=1 -> next cycle o_occupy=0, o_output_valid=0, no data emitted.
REQ-040 OUT_REG=1, DEPTH=4: push in cycle 0 -> o_output_valid rises in cycle 2; fill to 5 entries -> o_occupy=5, o_input_ready=0; streaming pops drain 1 per cycle.
REQ-041 Reset pulse with occupy=3 -> o_occupy=0 and o_output_valid=0 immediately; push X then pop -> X.
